// File: rtl/neonfox_dcache_pkg.sv
// Shared types and address-split helpers for the NeonFox direct-mapped data cache.
package neonfox_dcache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_FILL_REQ,
    ST_FILL
  } state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } wbuf_t;

  function automatic int offset_bits(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_bits(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_bits(input int lines, input int line_words);
    return 32 - $clog2(lines) - $clog2(line_words);
  endfunction

endpackage

// File: rtl/neonfox_dcache_line_ram.sv
// Cache data array: LINES x LINE_WORDS x 16 bits, combinational read, byte-enabled write.
// Zero-cycle read latency; writes land on the rising edge, no backpressure.
module dcache_line_ram
  import neonfox_dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic                              clk,
  input  logic [index_bits(LINES)-1:0]      rd_idx_i,
  input  logic [offset_bits(LINE_WORDS)-1:0] rd_off_i,
  output logic [15:0]                       rd_data_o,
  input  logic                              wr_en_i,
  input  logic [index_bits(LINES)-1:0]      wr_idx_i,
  input  logic [offset_bits(LINE_WORDS)-1:0] wr_off_i,
  input  logic [1:0]                        wr_be_i,
  input  logic [15:0]                       wr_data_i
);

  logic [15:0] mem_q [LINES*LINE_WORDS];

  assign rd_data_o = mem_q[{rd_idx_i, rd_off_i}];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (wr_be_i[1]) mem_q[{wr_idx_i, wr_off_i}][15:8] <= wr_data_i[15:8];
      if (wr_be_i[0]) mem_q[{wr_idx_i, wr_off_i}][7:0]  <= wr_data_i[7:0];
    end
  end

endmodule

// File: rtl/neonfox_dcache.sv
// Direct-mapped write-through, no-write-allocate data cache; hits answer combinationally.
// Misses and a busy one-entry write buffer stall the core via the *_miss outputs.
module neonfox_dcache
  import neonfox_dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_address,
  input  logic        data_ren,
  input  logic        data_wren,
  input  logic        H_en,
  input  logic        L_en,
  input  logic [15:0] data_out,
  output logic [15:0] data_in,
  output logic        d_cache_read_miss,
  output logic        d_cache_write_miss,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [15:0] mem_rdata
);

  localparam int OB = offset_bits(LINE_WORDS);
  localparam int IB = index_bits(LINES);
  localparam int TB = tag_bits(LINES, LINE_WORDS);

  state_e           state_q;
  wbuf_t            wbuf_q;
  logic             wbuf_vld_q;
  logic [LINES-1:0] valid_q;
  logic [TB-1:0]    tag_q [LINES];
  logic [OB-1:0]    beat_q;
  logic             mem_req_q, mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [15:0]      mem_wdata_q;
  logic [1:0]       mem_be_q;

  logic [OB-1:0] cpu_off;
  logic [IB-1:0] cpu_idx;
  logic [TB-1:0] cpu_tag;
  logic [IB-1:0] fill_idx;
  logic [TB-1:0] fill_tag;
  logic          hit, read_miss, write_miss, wr_acc, cpu_we, fill_we, fill_last;

  logic          ram_we;
  logic [IB-1:0] ram_idx;
  logic [OB-1:0] ram_off;
  logic [1:0]    ram_be;
  logic [15:0]   ram_wdata, ram_rd;

  assign cpu_off  = data_address[OB-1:0];
  assign cpu_idx  = data_address[OB+IB-1:OB];
  assign cpu_tag  = data_address[31:OB+IB];
  assign fill_idx = mem_addr_q[OB+IB-1:OB];
  assign fill_tag = mem_addr_q[31:OB+IB];

  assign hit       = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign read_miss = data_ren && !hit;
  // Fill beats own the data-array write port, so writes wait out an active fill.
  assign write_miss = data_wren && (wbuf_vld_q || read_miss || (state_q == ST_FILL));
  assign wr_acc     = data_wren && !write_miss;
  assign cpu_we     = wr_acc && hit;
  assign fill_we    = (state_q == ST_FILL) && mem_rvalid;
  assign fill_last  = (beat_q == OB'(LINE_WORDS - 1));

  always_comb begin
    ram_we    = 1'b0;
    ram_idx   = cpu_idx;
    ram_off   = cpu_off;
    ram_be    = 2'b00;
    ram_wdata = data_out;
    if (fill_we) begin
      ram_we    = 1'b1;
      ram_idx   = fill_idx;
      ram_off   = beat_q;
      ram_be    = 2'b11;
      ram_wdata = mem_rdata;
    end else if (cpu_we) begin
      ram_we = 1'b1;
      ram_be = {H_en, L_en};
    end
  end

  dcache_line_ram #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_data (
    .clk       (clk),
    .rd_idx_i  (cpu_idx),
    .rd_off_i  (cpu_off),
    .rd_data_o (ram_rd),
    .wr_en_i   (ram_we),
    .wr_idx_i  (ram_idx),
    .wr_off_i  (ram_off),
    .wr_be_i   (ram_be),
    .wr_data_i (ram_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wbuf_q      <= '0;
      wbuf_vld_q  <= 1'b0;
      valid_q     <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      beat_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      if (wr_acc) begin
        wbuf_q     <= '{addr: data_address, data: data_out, be: {H_en, L_en}};
        wbuf_vld_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          // Draining the buffer first keeps a later fill from reading stale memory.
          if (wbuf_vld_q) begin
            state_q     <= ST_WR;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= wbuf_q.addr;
            mem_wdata_q <= wbuf_q.data;
            mem_be_q    <= wbuf_q.be;
          end else if (read_miss) begin
            state_q    <= ST_FILL_REQ;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {data_address[31:OB], {OB{1'b0}}};
          end
        end
        ST_WR: begin
          if (mem_ack) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wbuf_vld_q <= 1'b0;
          end
        end
        ST_FILL_REQ: begin
          if (mem_ack) begin
            state_q           <= ST_FILL;
            mem_req_q         <= 1'b0;
            tag_q[fill_idx]   <= fill_tag;
            valid_q[fill_idx] <= 1'b0;
            beat_q            <= '0;
          end
        end
        ST_FILL: begin
          if (mem_rvalid) begin
            beat_q <= beat_q + OB'(1);
            if (fill_last) begin
              valid_q[fill_idx] <= 1'b1;
              state_q           <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_in            = data_ren ? ram_rd : 16'h0000;
  assign d_cache_read_miss  = read_miss;
  assign d_cache_write_miss = write_miss;
  assign mem_req            = mem_req_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign mem_be             = mem_be_q;

endmodule

// File: tb/tb_neonfox_dcache.sv
// Directed bench for neonfox_dcache with a behavioural SDRAM-side responder.
module tb_neonfox_dcache;

  localparam int LINES      = 64;
  localparam int LINE_WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_address;
  logic        data_ren, data_wren, H_en, L_en;
  logic [15:0] data_out;
  logic [15:0] data_in;
  logic        d_cache_read_miss, d_cache_write_miss;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [1:0]  mem_be;
  logic        mem_ack, mem_rvalid;
  logic [15:0] mem_rdata;

  always #5 clk = ~clk;

  neonfox_dcache #(.LINES(LINES), .LINE_WORDS(LINE_WORDS)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .data_address       (data_address),
    .data_ren           (data_ren),
    .data_wren          (data_wren),
    .H_en               (H_en),
    .L_en               (L_en),
    .data_out           (data_out),
    .data_in            (data_in),
    .d_cache_read_miss  (d_cache_read_miss),
    .d_cache_write_miss (d_cache_write_miss),
    .mem_req            (mem_req),
    .mem_we             (mem_we),
    .mem_addr           (mem_addr),
    .mem_wdata          (mem_wdata),
    .mem_be             (mem_be),
    .mem_ack            (mem_ack),
    .mem_rvalid         (mem_rvalid),
    .mem_rdata          (mem_rdata)
  );

  int tests = 0;
  int fails = 0;
  int ack_dly = 0;
  int wr_cnt = 0;
  int beat_no = -1;
  logic [31:0] last_addr;
  logic [15:0] last_wdata;
  logic [1:0]  last_be;
  bit          req_log[$];
  logic [15:0] mm [int unsigned];

  function automatic logic [15:0] mm_rd(input logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return 16'h5000 ^ a[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory side: ack after ack_dly extra cycles, then stream LINE_WORDS beats for a fill.
  initial begin
    bit          rq_we;
    logic [31:0] rq_a;
    logic [15:0] rq_d, w;
    logic [1:0]  rq_be;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1) begin
        rq_we = mem_we; rq_a = mem_addr; rq_d = mem_wdata; rq_be = mem_be;
        repeat (ack_dly) @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        req_log.push_back(rq_we);
        if (rq_we) begin
          w = mm_rd(rq_a);
          if (rq_be[1]) w[15:8] = rq_d[15:8];
          if (rq_be[0]) w[7:0]  = rq_d[7:0];
          mm[rq_a] = w;
          last_addr = rq_a; last_wdata = rq_d; last_be = rq_be;
          wr_cnt++;
        end else begin
          for (int k = 0; k < LINE_WORDS; k++) begin
            beat_no = k; mem_rvalid = 1'b1; mem_rdata = mm_rd(rq_a + k);
            @(negedge clk);
          end
          mem_rvalid = 1'b0; beat_no = -1;
        end
      end
    end
  end

  // Entered at a negedge; holds the read until it hits, returns at a later negedge.
  task automatic cpu_read(input logic [31:0] a, input logic [15:0] exp, input int exp_n, input string tag);
    int n = 0;
    logic [31:0] fa = 32'hFFFF_FFFF;
    data_address = a; data_ren = 1'b1; data_wren = 1'b0;
    #1;
    check({tag, ".miss"}, d_cache_read_miss, exp_n > 0);
    while (d_cache_read_miss !== 1'b0 && n < 200) begin
      @(negedge clk); #1; n++;
      if (mem_req === 1'b1 && mem_we === 1'b0) fa = mem_addr;
    end
    check({tag, ".stall"}, n, exp_n);
    check({tag, ".data"}, data_in, exp);
    if (exp_n > 0) check({tag, ".fill_addr"}, fa, {a[31:2], 2'b00});
    @(negedge clk);
    data_ren = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [15:0] d, input logic [1:0] be,
                           input int exp_stall, input string tag);
    int n = 0;
    data_address = a; data_out = d; H_en = be[1]; L_en = be[0];
    data_wren = 1'b1; data_ren = 1'b0;
    #1;
    while (d_cache_write_miss !== 1'b0 && n < 200) begin
      n++; @(negedge clk); #1;
    end
    check({tag, ".stall"}, n, exp_stall);
    @(negedge clk);
    data_wren = 1'b0; H_en = 1'b0; L_en = 1'b0;
  endtask

  task automatic wait_writes(input int target, input string tag);
    int n = 0;
    while (wr_cnt < target && n < 500) begin
      @(negedge clk); n++;
    end
    check(tag, wr_cnt, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; data_address = '0; data_ren = 1'b0; data_wren = 1'b0;
    H_en = 1'b0; L_en = 1'b0; data_out = '0;
    mm[32'h100] = 16'h00A0; mm[32'h101] = 16'h00A1;
    mm[32'h102] = 16'h00A2; mm[32'h103] = 16'h00A3;

    repeat (2) @(negedge clk);
    #1;
    check("rst.mem_req", mem_req, 0);
    check("rst.mem_we", mem_we, 0);
    check("rst.mem_addr", mem_addr, 0);
    check("rst.mem_wdata", mem_wdata, 0);
    check("rst.mem_be", mem_be, 0);
    check("rst.data_in", data_in, 0);
    check("rst.rd_miss", d_cache_read_miss, 0);
    check("rst.wr_miss", d_cache_write_miss, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Cold miss: 1 request cycle + 1 ack cycle + 4 beats before the hit lookup.
    cpu_read(32'h100, 16'h00A0, 6, "cold_rd");
    cpu_read(32'h102, 16'h00A2, 0, "hit_rd");

    cpu_write(32'h101, 16'hBEEF, 2'b10, 0, "wr_h");
    wait_writes(1, "wr_h.done");
    check("wr_h.addr", last_addr, 32'h101);
    check("wr_h.be", last_be, 2'b10);
    check("wr_h.wdata", last_wdata, 16'hBEEF);
    cpu_read(32'h101, 16'hBEA1, 0, "merge_rd");

    // Second write stalls for mem_req rise (1) plus a 4-cycle req-to-ack latency.
    ack_dly = 3;
    cpu_write(32'h102, 16'h1111, 2'b11, 0, "b2b_1");
    cpu_write(32'h103, 16'h2222, 2'b11, 5, "b2b_2");
    wait_writes(3, "b2b.done");
    ack_dly = 0;
    check("b2b.addr", last_addr, 32'h103);
    cpu_read(32'h103, 16'h2222, 0, "b2b_rd3");
    cpu_read(32'h102, 16'h1111, 0, "b2b_rd2");

    // Write miss then read: buffered write drains (2 extra cycles) before the fill.
    cpu_write(32'h2000, 16'h7777, 2'b11, 0, "wmiss");
    cpu_read(32'h2000, 16'h7777, 8, "wmiss_rd");
    check("order.first_is_write", req_log[req_log.size()-2], 1);
    check("order.then_fill", req_log[req_log.size()-1], 0);
    cpu_read(32'h2001, 16'h7001, 0, "wmiss_rd1");

    // Reset while a write waits for its ack.
    ack_dly = 40;
    cpu_write(32'h400, 16'h4444, 2'b11, 0, "rst_wr");
    repeat (2) @(negedge clk);
    #1;
    check("rst_wr.req_up", mem_req, 1);
    rst_n = 1'b0;
    #1;
    check("rst_wr.req_drop", mem_req, 0);
    check("rst_wr.we_drop", mem_we, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_writes(5, "rst_wr.ack_seen");
    ack_dly = 0;

    // Reset during fill beat 2; the remaining beats must be ignored.
    data_address = 32'h300; data_ren = 1'b1;
    n = 0;
    while (!(mem_rvalid === 1'b1 && beat_no == 2) && n < 100) begin
      @(negedge clk); #2; n++;
    end
    check("rst_fill.beat", beat_no, 2);
    rst_n = 1'b0;
    #1;
    check("rst_fill.req", mem_req, 0);
    check("rst_fill.line_inv", d_cache_read_miss, 1);
    @(negedge clk); rst_n = 1'b1; data_ren = 1'b0;
    repeat (4) @(negedge clk);
    cpu_read(32'h300, 16'h5300, 6, "rst_fill_rerd");

    // 0x100 and 0x200 share index 0: each access evicts the other.
    cpu_read(32'h100, 16'h00A0, 6, "conf_a1");
    cpu_read(32'h200, 16'h5200, 6, "conf_b1");
    cpu_read(32'h100, 16'h00A0, 6, "conf_a2");
    cpu_read(32'h103, 16'h2222, 0, "conf_a2_w3");
    cpu_read(32'h200, 16'h5200, 6, "conf_b2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
